// File: rtl/l1_dcache_ctrl.sv
// rtl/l1_dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   proc_ren/wen/addr/wdata         processor request (held stable while proc_stall=1)
//   proc_stall, proc_rdata          processor response
//   mem_read/write/addr/wdata       128-bit block memory request
//   mem_rdata, mem_ready            block memory response (mem_ready is a one-cycle pulse)
//   hit_count, miss_count           performance counters
//
// Optional feature macro: L1_DCACHE_PERF_CNT_EN builds the hit/miss counters;
// otherwise both counter outputs are tied to 0.
module l1_dcache_ctrl #(
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_ren,
    input  logic         proc_wen,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t            state_q, state_d;
    logic              wb_done_q, wb_done_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [127:0]      data_q [SETS];
    logic [127:0]      data_d [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [6:0]        bit_off;
    logic              req;
    logic              hit;

    assign idx     = proc_addr[IDX_W+1:2];
    assign tag     = proc_addr[29:IDX_W+2];
    assign bit_off = {proc_addr[1:0], 5'd0};
    assign req     = proc_ren | proc_wen;
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        wb_done_d  = 1'b0;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        mem_wdata  = 128'd0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (proc_wen) begin
                            data_d[idx][bit_off +: 32] = proc_wdata;
                            dirty_d[idx]               = 1'b1;
                        end else begin
                            proc_rdata = data_q[idx][bit_off +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                // After mem_ready the request drops for one turnaround cycle
                // before the fill is issued, so the memory sees two distinct requests.
                proc_stall = 1'b1;
                mem_write  = !wb_done_q;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = data_q[idx];
                if (wb_done_q) begin
                    state_d = S_ALLOCATE;
                end else if (mem_ready) begin
                    wb_done_d = 1'b1;
                end
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The idle-miss stall is combinational on the request, so hold it low during reset.
        if (!rst_n) begin
            proc_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wb_done_q <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            wb_done_q <= wb_done_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef L1_DCACHE_PERF_CNT_EN
    logic        refill_q, refill_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // refill_q marks the IDLE cycle that replays a request after its fill,
    // which must not be counted as a hit.
    always_comb begin
        refill_d     = (state_q == S_ALLOCATE) && mem_ready;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_IDLE && req) begin
            if (hit && !refill_q) begin
                hit_count_d = hit_count_q + 32'd1;
            end else if (!hit) begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_q     <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif
endmodule
